// File: rtl/imm_ctrl_pkg.sv
// Shared types and constants for the immediate-generation controller.
// Optional JAL/UJ support is enabled by defining IMM_UJ_EN.
package imm_ctrl_pkg;

    typedef enum logic [2:0] {
        FMT_I   = 3'd0,
        FMT_S   = 3'd1,
        FMT_SB  = 3'd2,
        FMT_U   = 3'd3,
        FMT_R   = 3'd4,
        FMT_UJ  = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXT  = 2'd1,
        OUT  = 2'd2
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] SEL_I  = 4'd0;
    localparam logic [3:0] SEL_S  = 4'd1;
    localparam logic [3:0] SEL_SB = 4'd2;
    localparam logic [3:0] SEL_U  = 4'd3;

    // True for formats whose immediate comes from the external extender.
    function automatic logic uses_extender(fmt_e fmt);
        return (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_SB) || (fmt == FMT_U);
    endfunction

endpackage

// File: rtl/imm_fmt_decode.sv
// Combinational opcode decoder: opcode -> immediate format, extender select, illegal flag.
// JAL decodes as UJ only when IMM_UJ_EN is defined.
module imm_fmt_decode
    import imm_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output fmt_e       fmt,
    output logic [3:0] sel,
    output logic       illegal
);

    always_comb begin
        fmt     = FMT_ILL;
        sel     = SEL_I;
        illegal = 1'b0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
                fmt = FMT_I;
                sel = SEL_I;
            end
            OP_STORE: begin
                fmt = FMT_S;
                sel = SEL_S;
            end
            OP_BRANCH: begin
                fmt = FMT_SB;
                sel = SEL_SB;
            end
            OP_LUI, OP_AUIPC: begin
                fmt = FMT_U;
                sel = SEL_U;
            end
            OP_REG: begin
                fmt = FMT_R;
            end
`ifdef IMM_UJ_EN
            OP_JAL: begin
                fmt = FMT_UJ;
            end
`else
            OP_JAL: begin
                fmt     = FMT_ILL;
                illegal = 1'b1;
            end
`endif
            default: begin
                fmt     = FMT_ILL;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_ctrl.sv
// Immediate-generation controller: accepts an instruction, drives an external extender
// for one cycle, then holds the captured immediate until handoff. IMM_UJ_EN adds JAL/UJ.
module imm_ctrl
    import imm_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [31:0] ext_instr,
    output logic [3:0]  ext_sel,
    input  logic [63:0] ext_imm,
    output logic        imm_valid,
    input  logic        imm_ready,
    output logic [63:0] imm,
    output logic [2:0]  imm_fmt,
    output logic        illegal,
    output logic [15:0] illegal_cnt
);

    state_e     state, next_state;
    fmt_e       fmt_q;
    fmt_e       dec_fmt;
    logic [3:0] dec_sel;
    logic       dec_illegal;
    logic       accept;

    imm_fmt_decode u_decode (
        .opcode  (instr[6:0]),
        .fmt     (dec_fmt),
        .sel     (dec_sel),
        .illegal (dec_illegal)
    );

`ifdef IMM_UJ_EN
    logic [63:0] uj_imm;
    assign uj_imm = {{43{ext_instr[31]}}, ext_instr[31], ext_instr[19:12],
                     ext_instr[20], ext_instr[30:21], 1'b0};
`endif

    always_comb begin
        next_state  = state;
        instr_ready = 1'b0;
        imm_valid   = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
            end
            EXT: begin
                next_state = OUT;
            end
            OUT: begin
                imm_valid   = 1'b1;
                instr_ready = imm_ready;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        accept = instr_valid && instr_ready;
        // A handoff in OUT either chains straight into the next accept or drops to IDLE.
        if (accept) begin
            next_state = EXT;
        end else if (state == OUT && imm_ready) begin
            next_state = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_instr   <= '0;
            ext_sel     <= '0;
            fmt_q       <= FMT_I;
            imm         <= '0;
            imm_fmt     <= '0;
            illegal     <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            if (accept) begin
                ext_instr <= instr;
                fmt_q     <= dec_fmt;
                if (uses_extender(dec_fmt)) begin
                    ext_sel <= dec_sel;
                end
                if (dec_illegal && illegal_cnt != '1) begin
                    illegal_cnt <= illegal_cnt + 16'd1;
                end
            end
            if (state == EXT) begin
                imm_fmt <= fmt_q;
                illegal <= (fmt_q == FMT_ILL);
                if (uses_extender(fmt_q)) begin
                    imm <= ext_imm;
`ifdef IMM_UJ_EN
                end else if (fmt_q == FMT_UJ) begin
                    imm <= uj_imm;
`endif
                end else begin
                    imm <= '0;
                end
            end
        end
    end

endmodule
